// File: rtl/mul8_acc.sv
`default_nettype none
// ============================================================================
// Module  : mul8_acc
// Brief   : Accumulates groups of 16-bit unsigned products from the 8x8
//           multiplier. A group closes after N_TERMS products or on in_last.
//           The result (sum, term count, overflow) is held until it is taken.
// Revision: 1.0 - initial release
// ============================================================================
module mul8_acc #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 19,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    S_ACC  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_ovf_q;

  logic [ACC_W:0]     sum_d;
  logic               ovf_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               close_d;
  logic               xfer_d;

  // A flush cycle must never also accept a product.
  assign in_ready  = (state_q == S_ACC) && !clr;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Next accumulator value with the carry kept as an extra top bit.
  always_comb begin
    sum_d   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_data};
    ovf_d   = ovf_q | sum_d[ACC_W];
    cnt_d   = cnt_q + CNT_W'(1);
    close_d = in_last || (cnt_q == CNT_W'(N_TERMS - 1));
    xfer_d  = in_valid && in_ready;
  end

  // Group FSM: accumulate in S_ACC, hold the captured result in S_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clr) begin
      // Result registers keep their last value; only the group is abandoned.
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (xfer_d) begin
            if (close_d) begin
              state_q     <= S_DONE;
              out_data_q  <= sum_d[ACC_W-1:0];
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
            end else begin
              acc_q <= sum_d[ACC_W-1:0];
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_ACC;
          end
        end
        default: begin
          state_q <= S_ACC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul8_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul8_acc
// Brief   : Scoreboard bench for mul8_acc (default build plus a narrow
//           ACC_W=16 / N_TERMS=2 build for the wrap-around cases).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul8_acc;

  typedef struct packed {
    logic [18:0] d;
    logic [3:0]  c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default-parameter instance
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] out_data;
  logic [3:0]  out_count;
  logic        out_ovf;

  // Narrow instance
  logic        n_clr = 1'b0;
  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [15:0] n_in_data = '0;
  logic        n_in_last = 1'b0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b1;
  logic [15:0] n_out_data;
  logic [3:0]  n_out_count;
  logic        n_out_ovf;

  exp_t q_main[$];
  exp_t q_nar[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mul8_acc u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  mul8_acc #(.N_TERMS(2), .ACC_W(16), .CNT_W(4)) u_nar (
    .clk(clk), .rst_n(rst_n), .clr(n_clr),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_last(n_in_last),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .out_count(n_out_count), .out_ovf(n_out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitors: compare a result against the scoreboard at each output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_main.size() == 0) chk("main_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_main.pop_front();
        chk("main_result", {out_ovf, out_count, out_data}, {8'd0, e.o, e.c, e.d});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && n_out_valid && n_out_ready) begin
      if (q_nar.size() == 0) chk("nar_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_nar.pop_front();
        chk("nar_result", {n_out_ovf, n_out_count, 3'd0, n_out_data}, {8'd0, e.o, e.c, e.d});
      end
    end
  end

  // Offer one product and return at posedge+1 after it was accepted.
  task automatic put(input logic [15:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && t < 50) begin t++; @(negedge clk); end
    if (!in_ready) chk("put_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic put_n(input logic [15:0] d, input logic l);
    int t = 0;
    n_in_valid = 1'b1; n_in_data = d; n_in_last = l;
    @(negedge clk);
    while (!n_in_ready && t < 50) begin t++; @(negedge clk); end
    if (!n_in_ready) chk("put_n_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    n_in_valid = 1'b0; n_in_last = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf",   out_ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Eight back-to-back 255*255 products close on the count.
    q_main.push_back('{d: 19'd520200, c: 4'd8, o: 1'b0});
    for (int i = 0; i < 8; i++) put(16'd65025, 1'b0);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("bubble_out_valid_drop", out_valid, 0);
    chk("bubble_in_ready_back", in_ready, 1);

    // Early close on in_last, then a fresh single-product group.
    q_main.push_back('{d: 19'd68, c: 4'd3, o: 1'b0});
    put(16'd6, 1'b0); put(16'd20, 1'b0); put(16'd42, 1'b1);
    @(posedge clk); #1;
    q_main.push_back('{d: 19'd5, c: 4'd1, o: 1'b0});
    put(16'd5, 1'b1);
    @(posedge clk); #1;

    // Backpressure: result held, inputs refused.
    out_ready = 1'b0;
    q_main.push_back('{d: 19'd30, c: 4'd2, o: 1'b0});
    put(16'd10, 1'b0); put(16'd20, 1'b1);
    in_valid = 1'b1; in_data = 16'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 30);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    q_main.push_back('{d: 19'd1, c: 4'd1, o: 1'b0});
    put(16'd1, 1'b1);
    @(posedge clk); #1;

    // Narrow build: wrap-around and overflow flag, then a clean group.
    q_nar.push_back('{d: 19'd64514, c: 4'd2, o: 1'b1});
    put_n(16'd65025, 1'b0); put_n(16'd65025, 1'b0);
    @(posedge clk); #1;
    q_nar.push_back('{d: 19'd3, c: 4'd2, o: 1'b0});
    put_n(16'd1, 1'b0); put_n(16'd2, 1'b0);
    @(posedge clk); #1;

    // Flush mid-group; the product offered alongside clr is refused.
    put(16'd100, 1'b0); put(16'd100, 1'b0); put(16'd100, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'd50;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    q_main.push_back('{d: 19'd15, c: 4'd2, o: 1'b0});
    put(16'd7, 1'b0); put(16'd8, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset mid-group: result registers clear without an edge.
    put(16'd500, 1'b0); put(16'd500, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_out_data", out_data, 0);
    chk("arst_mid_out_count", out_count, 0);
    chk("arst_mid_out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    put(16'd9, 1'b1);
    chk("pre_arst_done_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_out_valid", out_valid, 0);
    chk("arst_done_out_data", out_data, 0);
    chk("arst_done_out_count", out_count, 0);
    chk("arst_done_out_ovf", out_ovf, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    q_main.push_back('{d: 19'd4000, c: 4'd4, o: 1'b0});
    put(16'd1000, 1'b0); put(16'd1000, 1'b0); put(16'd1000, 1'b0); put(16'd1000, 1'b1);

    // Drain: every expected result must have been seen.
    for (int t = 0; t < 50 && (q_main.size() != 0 || q_nar.size() != 0); t++) @(posedge clk);
    #1;
    chk("drain_main", q_main.size(), 0);
    chk("drain_nar", q_nar.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
